bakery_server: RTL and testbench

- Centralized ticket dispenser and "now serving" caller for the bakery mutual-exclusion protocol; it is the responder side to client processes that request entry to the critical section.
- Hands out monotonically increasing wrap-around tickets, calls tickets in order, and grants exactly one client at a time.
- Ties between simultaneous requests go to the lower client index, matching the distributed bakery priority rule.
- Sits beside the bakery client models as a centralized reference implementation; property monitors check it.

---
 rtl/bakery_server_if.sv | 38 +++
 rtl/bakery_server.sv | 197 +++++++++++++++++++
 tb/tb_bakery_server.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bakery_server_if.sv
`default_nettype none
// ============================================================================
//  Module      : bakery_server_if
//  Description : Client-side bundle of the bakery ticket server.
//                master = client side (drives req/rel)
//                slave  = server side (drives issued/waiting/grant/counters)
//  Ports       : req[NPROC]     client asks for a ticket (level)
//                rel[NPROC]     client leaves the critical section (level)
//                issued[NPROC]  one-cycle pulse, ticket handed to client i
//                waiting[NPROC] client i holds a ticket, not yet granted
//                grant[NPROC]   one-hot or zero, client in critical section
//                serving[TW]    ticket number currently called
//                next_ticket[TW] number the next ticket will carry
//  Revision    : 1.0  initial release
// ============================================================================
interface bakery_server_if #(
    parameter int NPROC = 3,
    parameter int TW    = 2
);
    logic [NPROC-1:0] req;
    logic [NPROC-1:0] rel;
    logic [NPROC-1:0] issued;
    logic [NPROC-1:0] waiting;
    logic [NPROC-1:0] grant;
    logic [TW-1:0]    serving;
    logic [TW-1:0]    next_ticket;

    modport master (
        output req, rel,
        input  issued, waiting, grant, serving, next_ticket
    );

    modport slave (
        input  req, rel,
        output issued, waiting, grant, serving, next_ticket
    );
endinterface
`default_nettype wire

// File: rtl/bakery_server.sv
`default_nettype none
// ============================================================================
//  Module      : bakery_server
//  Description : Centralized bakery ticket dispenser and "now serving" caller.
//                Issues at most one wrap-around ticket per cycle (lowest idle
//                requester first), calls tickets in order and grants a single
//                client at a time. All outputs come from registers.
//  Ports       : clock   single clock, rising edge
//                rst_n   asynchronous active-low reset
//                bus     bakery_server_if.slave (req/rel in, status out)
//                err     sticky protocol-check flag (only with the macro)
//  Options     : BAKERY_SERVER_CHECK_EN adds the err port and its checkers.
//  Revision    : 1.0  initial release
// ============================================================================
module bakery_server #(
    parameter int NPROC = 3,
    parameter int TW    = 2
) (
    input  wire logic         clock,
    input  wire logic         rst_n,
    bakery_server_if.slave    bus
`ifdef BAKERY_SERVER_CHECK_EN
    ,
    output logic              err
`endif
);

    // Tickets are only unique if every client can hold a distinct value.
    generate
        if (NPROC > (2 ** TW)) begin : g_param_check
            $error("bakery_server: NPROC must not exceed 2**TW");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_CRIT = 2'd2
    } state_t;

    state_t           r_state     [NPROC];
    state_t           w_state_nxt [NPROC];
    logic [TW-1:0]    r_tkt       [NPROC];
    logic [TW-1:0]    w_tkt_nxt   [NPROC];
    logic [TW-1:0]    r_serving;
    logic [TW-1:0]    w_serving_nxt;
    logic [TW-1:0]    r_next_ticket;
    logic [TW-1:0]    w_next_nxt;
    logic [NPROC-1:0] r_issued;
    logic [NPROC-1:0] w_issued_nxt;
    logic [NPROC-1:0] w_waiting;
    logic [NPROC-1:0] w_grant;
    logic             w_any_crit;
    logic             w_issue_done;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NPROC; i++) begin
                r_state[i] <= ST_IDLE;
                r_tkt[i]   <= '0;
            end
            r_serving     <= '0;
            r_next_ticket <= '0;
            r_issued      <= '0;
        end else begin
            for (int i = 0; i < NPROC; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_tkt[i]   <= w_tkt_nxt[i];
            end
            r_serving     <= w_serving_nxt;
            r_next_ticket <= w_next_nxt;
            r_issued      <= w_issued_nxt;
        end
    end

    // ------------------------------------------------------ next state
    always_comb begin
        w_serving_nxt = r_serving;
        w_next_nxt    = r_next_ticket;
        w_issued_nxt  = '0;
        w_any_crit    = 1'b0;
        w_issue_done  = 1'b0;
        for (int i = 0; i < NPROC; i++) begin
            w_state_nxt[i] = r_state[i];
            w_tkt_nxt[i]   = r_tkt[i];
            if (r_state[i] == ST_CRIT) begin
                w_any_crit = 1'b1;
            end
        end

        for (int i = 0; i < NPROC; i++) begin
            case (r_state[i])
                ST_IDLE: begin
                    // Ascending scan: the first idle requester wins the tie.
                    if (bus.req[i] && !w_issue_done) begin
                        w_issue_done    = 1'b1;
                        w_state_nxt[i]  = ST_WAIT;
                        w_tkt_nxt[i]    = r_next_ticket;
                        w_issued_nxt[i] = 1'b1;
                        w_next_nxt      = r_next_ticket + TW'(1);
                    end
                end
                ST_WAIT: begin
                    // Grant is blocked by any current holder, which yields
                    // the dead cycle after every release.
                    if (!w_any_crit && (r_tkt[i] == r_serving)) begin
                        w_state_nxt[i] = ST_CRIT;
                    end
                end
                ST_CRIT: begin
                    if (bus.rel[i]) begin
                        w_state_nxt[i] = ST_IDLE;
                        w_serving_nxt  = r_serving + TW'(1);
                    end
                end
                default: begin
                    w_state_nxt[i] = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------ outputs
    always_comb begin
        w_waiting = '0;
        w_grant   = '0;
        for (int i = 0; i < NPROC; i++) begin
            w_waiting[i] = (r_state[i] == ST_WAIT);
            w_grant[i]   = (r_state[i] == ST_CRIT);
        end
    end

    assign bus.issued      = r_issued;
    assign bus.waiting     = w_waiting;
    assign bus.grant       = w_grant;
    assign bus.serving     = r_serving;
    assign bus.next_ticket = r_next_ticket;

`ifdef BAKERY_SERVER_CHECK_EN
    // Starvation counts only cycles in which nobody holds the section, so a
    // long critical section does not flag the clients queued behind it.
    localparam int C_LIMIT = NPROC * 8;
    localparam int C_CW    = $clog2(C_LIMIT + 2);
    localparam logic [C_CW-1:0] c_limit = C_CW'(C_LIMIT);
    localparam logic [C_CW-1:0] c_sat   = C_CW'(C_LIMIT + 1);

    logic [C_CW-1:0] r_wait_cnt [NPROC];
    logic            r_err;
    logic            w_err_now;
    int              w_grant_cnt;

    always_comb begin
        w_err_now   = 1'b0;
        w_grant_cnt = 0;
        for (int i = 0; i < NPROC; i++) begin
            if (w_grant[i]) begin
                w_grant_cnt = w_grant_cnt + 1;
            end
            if (r_wait_cnt[i] > c_limit) begin
                w_err_now = 1'b1;
            end
            for (int j = i + 1; j < NPROC; j++) begin
                if ((r_state[i] != ST_IDLE) && (r_state[j] != ST_IDLE) &&
                    (r_tkt[i] == r_tkt[j])) begin
                    w_err_now = 1'b1;
                end
            end
        end
        if (w_grant_cnt > 1) begin
            w_err_now = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NPROC; i++) begin
                r_wait_cnt[i] <= '0;
            end
            r_err <= 1'b0;
        end else begin
            for (int i = 0; i < NPROC; i++) begin
                if (r_state[i] != ST_WAIT) begin
                    r_wait_cnt[i] <= '0;
                end else if (!w_any_crit && (r_wait_cnt[i] != c_sat)) begin
                    r_wait_cnt[i] <= r_wait_cnt[i] + C_CW'(1);
                end
            end
            r_err <= r_err | w_err_now;
        end
    end

    assign err = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bakery_server.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bakery_server
//  Description : Self-checking bench for bakery_server. Directed table of
//                vectors, hand-written wrap / same-edge / async-reset
//                sequences, then random traffic against a queue-based model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bakery_server;
    localparam int NPROC = 3;
    localparam int TW    = 2;
    localparam int MOD   = 1 << TW;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    bakery_server_if #(.NPROC(NPROC), .TW(TW)) bus ();
`ifdef BAKERY_SERVER_CHECK_EN
    logic err;
`endif

    bakery_server #(.NPROC(NPROC), .TW(TW)) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef BAKERY_SERVER_CHECK_EN
        ,
        .err   (err)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------- model
    // Waiting clients are a list ordered by ticket; one optional holder.
    int q_id  [$];
    int q_tkt [$];
    int holder;
    int m_serv;
    int m_next;
    int m_issued;

    function automatic void model_reset();
        q_id.delete();
        q_tkt.delete();
        holder   = -1;
        m_serv   = 0;
        m_next   = 0;
        m_issued = 0;
    endfunction

    function automatic bit busy(input int c);
        if (holder == c) return 1'b1;
        foreach (q_id[k]) if (q_id[k] == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_edge(input logic [2:0] rq, input logic [2:0] rl);
        int idx;
        int new_holder;
        int new_serv;
        idx = -1;
        for (int i = 0; i < NPROC; i++) begin
            if (idx < 0 && rq[i] && !busy(i)) idx = i;
        end
        new_holder = holder;
        new_serv   = m_serv;
        if (holder >= 0) begin
            if (rl[holder]) begin
                new_holder = -1;
                new_serv   = (m_serv + 1) % MOD;
            end
        end else begin
            for (int k = 0; k < q_id.size(); k++) begin
                if (q_tkt[k] == m_serv) begin
                    new_holder = q_id[k];
                    q_id.delete(k);
                    q_tkt.delete(k);
                    break;
                end
            end
        end
        holder   = new_holder;
        m_serv   = new_serv;
        m_issued = 0;
        if (idx >= 0) begin
            q_id.push_back(idx);
            q_tkt.push_back(m_next);
            m_next   = (m_next + 1) % MOD;
            m_issued = 1 << idx;
        end
    endfunction

    function automatic int exp_waiting();
        int w;
        w = 0;
        foreach (q_id[k]) w |= (1 << q_id[k]);
        return w;
    endfunction

    task automatic compare_model();
        chk("issued",      bus.issued,      m_issued);
        chk("waiting",     bus.waiting,     exp_waiting());
        chk("grant",       bus.grant,       (holder >= 0) ? (1 << holder) : 0);
        chk("serving",     bus.serving,     m_serv);
        chk("next_ticket", bus.next_ticket, m_next);
`ifdef BAKERY_SERVER_CHECK_EN
        chk("err",         err,             0);
`endif
    endtask

    task automatic step(input logic [2:0] rq, input logic [2:0] rl);
        @(negedge clock);
        bus.req = rq;
        bus.rel = rl;
        @(posedge clock);
        model_edge(rq, rl);
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        @(negedge clock);
        bus.req = '0;
        bus.rel = '0;
        rst_n   = 1'b0;
        #1;
        model_reset();
        @(negedge clock);
        rst_n = 1'b1;
        #1;
    endtask

    // ---------------------------------------------------------- table
    typedef struct {
        logic       rst;
        logic [2:0] req;
        logic [2:0] rel;
        logic [2:0] issued;
        logic [2:0] waiting;
        logic [2:0] grant;
        logic [1:0] serv;
        logic [1:0] nxt;
    } vec_t;

    vec_t tbl [15];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bus.req = '0;
        bus.rel = '0;
        model_reset();

        //           rst   req     rel     issued  waiting grant   s      n
        tbl[0]  = '{1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 2'd0, 2'd0};
        tbl[1]  = '{1'b0, 3'b001, 3'b000, 3'b001, 3'b001, 3'b000, 2'd0, 2'd1};
        tbl[2]  = '{1'b0, 3'b001, 3'b000, 3'b000, 3'b000, 3'b001, 2'd0, 2'd1};
        tbl[3]  = '{1'b0, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 2'd1, 2'd1};
        tbl[4]  = '{1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 2'd0, 2'd0};
        tbl[5]  = '{1'b0, 3'b111, 3'b000, 3'b001, 3'b001, 3'b000, 2'd0, 2'd1};
        tbl[6]  = '{1'b0, 3'b111, 3'b000, 3'b010, 3'b010, 3'b001, 2'd0, 2'd2};
        tbl[7]  = '{1'b0, 3'b111, 3'b010, 3'b100, 3'b110, 3'b001, 2'd0, 2'd3};
        tbl[8]  = '{1'b0, 3'b000, 3'b001, 3'b000, 3'b110, 3'b000, 2'd1, 2'd3};
        tbl[9]  = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b100, 3'b010, 2'd1, 2'd3};
        tbl[10] = '{1'b0, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 2'd2, 2'd3};
        tbl[11] = '{1'b0, 3'b100, 3'b000, 3'b000, 3'b000, 3'b100, 2'd2, 2'd3};
        tbl[12] = '{1'b0, 3'b100, 3'b000, 3'b000, 3'b000, 3'b100, 2'd2, 2'd3};
        tbl[13] = '{1'b0, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000, 2'd3, 2'd3};
        tbl[14] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 2'd3, 2'd3};

        repeat (2) @(posedge clock);
        for (int r = 0; r < 15; r++) begin
            if (tbl[r].rst) do_reset();
            else            step(tbl[r].req, tbl[r].rel);
            chk($sformatf("tbl%0d.issued", r),  bus.issued,      tbl[r].issued);
            chk($sformatf("tbl%0d.waiting", r), bus.waiting,     tbl[r].waiting);
            chk($sformatf("tbl%0d.grant", r),   bus.grant,       tbl[r].grant);
            chk($sformatf("tbl%0d.serving", r), bus.serving,     tbl[r].serv);
            chk($sformatf("tbl%0d.next", r),    bus.next_ticket, tbl[r].nxt);
        end

        // Wrap: client 2 alone for five rounds, starting from serving=3.
        for (int r = 0; r < 5; r++) begin
            step(3'b100, 3'b000);
            chk("wrap.next", bus.next_ticket, (3 + r + 1) % MOD);
            step(3'b000, 3'b000);
            chk("wrap.grant", bus.grant, 3'b100);
            step(3'b000, 3'b100);
            chk("wrap.serving", bus.serving, (3 + r + 1) % MOD);
        end

        // Client 1 releases on the same edge client 0 receives a ticket.
        step(3'b010, 3'b000);
        step(3'b000, 3'b000);
        chk("same.grant1", bus.grant, 3'b010);
        step(3'b001, 3'b010);
        chk("same.issued", bus.issued, 3'b001);
        chk("same.grant_dead", bus.grant, 3'b000);
        step(3'b000, 3'b000);
        chk("same.grant0", bus.grant, 3'b001);
        step(3'b000, 3'b001);

        // Asynchronous reset while client 0 is CRIT and client 2 is WAIT.
        step(3'b001, 3'b000);
        step(3'b100, 3'b000);
        chk("arst.pre_grant", bus.grant, 3'b001);
        chk("arst.pre_wait",  bus.waiting, 3'b100);
        @(negedge clock);
        bus.req = '0;
        bus.rel = '0;
        @(posedge clock);
        model_edge(3'b000, 3'b000);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst.issued",  bus.issued,      0);
        chk("arst.waiting", bus.waiting,     0);
        chk("arst.grant",   bus.grant,       0);
        chk("arst.serving", bus.serving,     0);
        chk("arst.next",    bus.next_ticket, 0);
        model_reset();
        @(negedge clock);
        rst_n = 1'b1;

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            step(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
